// File: rtl/shift_pkg.sv
// Shared definitions for the bidirectional shift register and its serial collector.
package shift_pkg;

    // Default word width shared by the shift register and the collector.
    localparam int SHIFT_N = 4;

    // Direction encoding matches the shift register's dir input.
    localparam logic DIR_LEFT  = 1'b0;   // producer shifts left, bits arrive MSB-first
    localparam logic DIR_RIGHT = 1'b1;   // producer shifts right, bits arrive LSB-first

    // Collector state: IDLE means no partial word (cnt == 0).
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } col_state_t;

endpackage : shift_pkg

// File: rtl/shift_collect_obuf.sv
// One-entry valid/ready holding register for completed words, with a sticky
// overrun flag raised whenever a completed word finds the buffer occupied.
module shift_collect_obuf
    import shift_pkg::*;
#(
    parameter int N = SHIFT_N
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         overrun
);

    logic         valid_r;
    logic [N-1:0] data_r;
    logic         over_r;

    logic         valid_s;
    logic [N-1:0] data_s;
    logic         over_s;
    logic         pop_s;

    // Next-state logic: clear wins, then push (accepted if empty or draining), then pop.
    always_comb begin
        pop_s   = valid_r && out_ready;
        valid_s = valid_r;
        data_s  = data_r;
        over_s  = over_r;
        if (clear) begin
            valid_s = 1'b0;
            over_s  = 1'b0;
        end else if (push) begin
            if (!valid_r || pop_s) begin
                valid_s = 1'b1;
                data_s  = push_data;
            end else begin
                over_s  = 1'b1;
            end
        end else if (pop_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // Buffer state registers with asynchronous reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            data_r  <= {N{1'b0}};
            over_r  <= 1'b0;
        end else begin
            valid_r <= valid_s;
            data_r  <= data_s;
            over_r  <= over_s;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign overrun   = over_r;

endmodule : shift_collect_obuf

// File: rtl/shift_collect.sv
// Serial-to-parallel collector: reassembles N-bit words from the serial output
// of the bidirectional shift register, in the order the bits were shifted out.
// The direction is latched on the first bit of each word. Requires N >= 2 and
// 2**CW >= N.
module shift_collect
    import shift_pkg::*;
#(
    parameter int N  = SHIFT_N,
    parameter int CW = 3
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         en,
    input  logic         din,
    input  logic         dir,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         overrun,
    output logic         busy
);

    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    col_state_t    state_r;
    col_state_t    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  acc_s;
    logic          word_dir_r;
    logic          word_dir_s;

    logic          eff_dir_s;
    logic [N-1:0]  shifted_s;
    logic          complete_s;

    // Insert one serial bit into the accumulator on the side matching the direction.
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] a,
                                              input logic         b,
                                              input logic         d);
        if (d == DIR_RIGHT) begin
            return {b, a[N-1:1]};
        end else begin
            return {a[N-2:0], b};
        end
    endfunction

    // Accumulator/counter state register with asynchronous reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {N{1'b0}};
            word_dir_r <= DIR_LEFT;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            word_dir_r <= word_dir_s;
        end
    end

    // Next-state logic: first bit in IDLE latches dir; the bit at cnt==N-1 completes the word.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        acc_s      = acc_r;
        word_dir_s = word_dir_r;
        complete_s = 1'b0;
        eff_dir_s  = (state_r == IDLE) ? dir : word_dir_r;
        shifted_s  = shift_in(acc_r, din, eff_dir_s);
        if (clear) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
            acc_s   = {N{1'b0}};
        end else if (en) begin
            acc_s      = shifted_s;
            word_dir_s = eff_dir_s;
            case (state_r)
                IDLE: begin
                    cnt_s   = {{(CW-1){1'b0}}, 1'b1};
                    state_s = COLLECT;
                end
                COLLECT: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_s      = {CW{1'b0}};
                        state_s    = IDLE;
                        complete_s = 1'b1;
                    end else begin
                        cnt_s      = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign busy = (state_r == COLLECT);

    shift_collect_obuf #(
        .N (N)
    ) u_obuf (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .push      (complete_s),
        .push_data (shifted_s),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .overrun   (overrun)
    );

endmodule : shift_collect

// File: tb/tb_shift_collect.sv
// Directed bench for shift_collect: a bit-list model of word assembly and the
// one-entry output buffer, compared every cycle, plus literal expectations.
module tb_shift_collect;

    localparam int N = 4;

    logic         clock;
    logic         resetn;
    logic         clear;
    logic         en;
    logic         din;
    logic         dir;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         overrun;
    logic         busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int       m_cnt;
    logic     m_bits [N];
    logic     m_dir;
    logic     m_valid;
    logic [N-1:0] m_data;
    logic     m_over;
    int       pulses;

    shift_collect #(.N(N), .CW(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .en        (en),
        .din       (din),
        .dir       (dir),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_dir   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_over  = 1'b0;
        for (int i = 0; i < N; i++) m_bits[i] = 1'b0;
    endtask

    // Word value from the list of received bits, in arrival order.
    function automatic logic [N-1:0] assemble(input logic d);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (d) w[i] = m_bits[i];
            else   w[N-1-i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_step(input logic e, input logic d, input logic dr,
                              input logic rdy, input logic clr);
        logic         pop;
        logic         done;
        logic [N-1:0] word;
        pop  = m_valid && rdy;
        done = 1'b0;
        word = '0;
        if (clr) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_over  = 1'b0;
        end else begin
            if (e) begin
                if (m_cnt == 0) m_dir = dr;
                m_bits[m_cnt] = d;
                m_cnt++;
                if (m_cnt == N) begin
                    done  = 1'b1;
                    word  = assemble(m_dir);
                    m_cnt = 0;
                end
            end
            if (done) begin
                if (!m_valid || pop) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end else if (pop) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive one clock of inputs, advance the model at the edge, return at the next negedge.
    task automatic step(input logic e, input logic d, input logic dr,
                        input logic rdy, input logic clr);
        en        = e;
        din       = d;
        dir       = dr;
        out_ready = rdy;
        clear     = clr;
        @(posedge clock);
        model_step(e, d, dr, rdy, clr);
        if (m_valid) pulses++;
        @(negedge clock);
    endtask

    task automatic send_word(input logic [N-1:0] bits, input logic dr, input logic rdy);
        for (int i = 0; i < N; i++) step(1'b1, bits[i], dr, rdy, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("overrun",   {31'd0, overrun},   {31'd0, m_over});
            check("busy",      {31'd0, busy},      {31'd0, (m_cnt != 0)});
            if (m_valid) check("out_data", {28'd0, out_data}, {28'd0, m_data});
        end
    end

    initial begin
        logic [N-1:0] w;
        resetn = 1'b0; clear = 1'b0; en = 1'b0; din = 1'b0; dir = 1'b0; out_ready = 1'b0;
        pulses = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data",  {28'd0, out_data},  32'd0);
        check("reset_over",  {31'd0, overrun},   32'd0);
        check("reset_busy",  {31'd0, busy},      32'd0);
        resetn = 1'b1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first 1,0,1,1 -> 1101
        w = 4'b1101; send_word(w, 1'b1, 1'b0);
        check("lsb_valid", {31'd0, out_valid}, 32'd1);
        check("lsb_data",  {28'd0, out_data},  32'hD);
        check("lsb_busy",  {31'd0, busy},      32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // MSB-first 1,0,1,1 -> 1011
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("msb_data", {28'd0, out_data}, 32'hB);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // direction latched on first bit: dir 0 then 1, din 0,1,1,0 -> 0110
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("latch_data", {28'd0, out_data}, 32'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // gapped en 1,0,0,1,0,1,1 with bits 1,1,0,0 LSB-first -> 0011
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_busy1", {31'd0, busy}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_busy_hold", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_busy3", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_data", {28'd0, out_data}, 32'h3);
        check("gap_busy_end", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // overrun: 0001 retained, 1110 dropped
        w = 4'b0001; send_word(w, 1'b1, 1'b0);
        w = 4'b1110; send_word(w, 1'b1, 1'b0);
        check("ovr_data", {28'd0, out_data}, 32'h1);
        check("ovr_flag", {31'd0, overrun},  32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_pop_valid", {31'd0, out_valid}, 32'd0);
        check("ovr_sticky",    {31'd0, overrun},   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // clear overrides a same-cycle completion
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_busy",  {31'd0, busy},      32'd0);

        // throughput: continuous bits with out_ready=1
        pulses = 0;
        w = 4'b1010; send_word(w, 1'b1, 1'b1);
        check("tp_data1", {28'd0, out_data}, 32'hA);
        w = 4'b0101; send_word(w, 1'b1, 1'b1);
        check("tp_data2", {28'd0, out_data}, 32'h5);
        w = 4'b1001; send_word(w, 1'b0, 1'b1);
        check("tp_data3", {28'd0, out_data}, 32'h9);
        check("tp_pulses", pulses, 32'd3);
        check("tp_over",   {31'd0, overrun}, 32'd0);

        // asynchronous reset with a full buffer and a partial word
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        w = 4'b0111; send_word(w, 1'b1, 1'b0);
        check("post_rst_data",  {28'd0, out_data},  32'h7);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_collect
